// File: rtl/pcm_dac4_shaper.sv
// PCM to 4-bit ladder DAC stage: offset-binary conversion, clk/DIV update rate,
// first-order error-feedback noise shaping with saturation and mute.
module pcm_dac4_shaper #(
  parameter int PCM_BITS = 12,
  parameter int DAC_BITS = 4,
  parameter int DIV      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mute,
  input  logic [PCM_BITS-1:0] pcm,
  output logic                tick,
  output logic [DAC_BITS-1:0] dac
);

  localparam int E  = PCM_BITS - DAC_BITS;
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] LAST =
    CW'(DIV - 1);
  localparam logic [DAC_BITS-1:0] MID =
    DAC_BITS'(1 << (DAC_BITS - 1));
  localparam logic [PCM_BITS-1:0] UMID =
    PCM_BITS'(1 << (PCM_BITS - 1));

  logic [CW-1:0]       div_cnt;
  logic [E-1:0]        err;
  logic                upd;
  logic [PCM_BITS-1:0] u;
  logic [PCM_BITS:0]   sum;

  always_comb begin
    upd = (div_cnt == LAST);
    u   = {~pcm[PCM_BITS-1], pcm[PCM_BITS-2:0]};
    if (mute) u = UMID;
    sum = {1'b0, u} + {{(DAC_BITS+1){1'b0}}, err};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      err     <= '0;
      tick    <= 1'b0;
      dac     <= MID;
    end else begin
      div_cnt <= upd ? '0 : div_cnt + CW'(1);
      tick    <= upd;
      if (upd) begin
        // carry out of the sum saturates rather than wrapping to zero
        if (sum[PCM_BITS]) begin
          dac <= '1;
          err <= '0;
        end else begin
          dac <= sum[PCM_BITS-1:E];
          err <= sum[E-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_dac4_shaper.sv
// Bench for pcm_dac4_shaper: directed scenarios plus random pcm/mute/rst,
// checked every cycle against an arithmetic reference model.
module tb_pcm_dac4_shaper;

  localparam int PB  = 12;
  localparam int DB  = 4;
  localparam int DIV = 16;
  localparam int EB  = PB - DB;

  logic          clk = 1'b0;
  logic          rst;
  logic          mute;
  logic [PB-1:0] pcm;
  logic          tick;
  logic [DB-1:0] dac;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_n;
  int m_err;
  int m_dac;
  int m_tick;

  pcm_dac4_shaper #(
    .PCM_BITS(PB),
    .DAC_BITS(DB),
    .DIV(DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mute(mute),
    .pcm (pcm),
    .tick(tick),
    .dac (dac)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Model the coming edge from current inputs, clock it, compare outputs.
  task automatic step();
    int u;
    int total;
    if (rst) begin
      m_n = 0; m_err = 0; m_dac = 2**(DB-1); m_tick = 0;
    end else begin
      m_n++;
      m_tick = (m_n % DIV == 0) ? 1 : 0;
      if (m_tick == 1) begin
        u = mute ? 2**(PB-1)
                 : int'($signed(pcm)) + 2**(PB-1);
        total = u + m_err;
        if (total >= 2**PB) begin
          m_dac = 2**DB - 1; m_err = 0;
        end else begin
          m_dac = total / 2**EB; m_err = total % 2**EB;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("dac", int'(dac), m_dac);
    chk("tick", int'(tick), m_tick);
  endtask

  task automatic run_updates(input int n,
                             output int dsum);
    int seen;
    int budget;
    seen = 0; dsum = 0; budget = (n + 1) * DIV;
    while (seen < n && budget > 0) begin
      step();
      budget--;
      if (tick) begin
        seen++; dsum += int'(dac);
      end
    end
    chk("update_budget", seen, n);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int s;
    rst = 1'b1; mute = 1'b0; pcm = '0;
    m_n = 0; m_err = 0; m_dac = 8; m_tick = 0;

    // 1: reset state, first tick position, tick period
    do_reset(3);
    chk("reset_dac", int'(dac), 8);
    chk("reset_tick", int'(tick), 0);
    k = 0;
    while (k < 4 * DIV) begin
      step(); k++;
      if (tick) break;
    end
    chk("first_tick_cycle", k, DIV);
    for (int j = 1; j <= DIV; j++) begin
      step();
      chk("tick_period", int'(tick), (j == DIV) ? 1 : 0);
    end

    // 2: positive full scale saturates at 15
    pcm = 12'h7ff;
    for (int j = 0; j < 8; j++) begin
      run_updates(1, s);
      chk("sat_hi", s, 15);
    end

    // 3: negative full scale holds 0
    pcm = 12'h800;
    for (int j = 0; j < 8; j++) begin
      run_updates(1, s);
      chk("full_neg", s, 0);
    end

    // 4: pcm=16 from reset, exact mean over 256 updates
    do_reset(2);
    pcm = 12'd16;
    for (int j = 1; j <= 16; j++) begin
      run_updates(1, s);
      chk("pcm16_pattern", s, (j == 16) ? 9 : 8);
    end
    run_updates(256, s);
    chk("pcm16_sum256", s, 256 * 8 + 16);

    // 5: mute while shaping, then release
    do_reset(1);
    pcm = 12'd1000;
    run_updates(20, s);
    mute = 1'b1;
    run_updates(40, s);
    run_updates(1, s);
    chk("mute_steady", s, 8);
    mute = 1'b0;
    run_updates(20, s);

    // 6: reset mid-period with pcm=+500
    pcm = 12'd500;
    repeat (DIV + 7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_dac", int'(dac), 8);
    chk("midrst_tick", int'(tick), 0);
    run_updates(12, s);

    // random pcm/mute with occasional reset
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 15) == 0) pcm = PB'($urandom);
      if ($urandom_range(0, 99) == 0) mute = ~mute;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    mute = 1'b0;
    repeat (DIV) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
